// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan display.
//   SEG_BLANK  - all segments off (active-low code).
//   HEX_SEG    - 16-entry hex -> segment table, active-low, bit order {CA..CG}
//                (CA is bit 6, CG is bit 0). Index with the nibble value.
//   scan_state_t - scan FSM state: GUARD (dead time) / SHOW (digit lit).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the code for hex digit n; the literal lists F first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low 7-segment decode.
//   digit  in  4  hex value 0..F
//   seg    out 7  active-low segments {CA,CB,CC,CD,CE,CF,CG}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for a common-anode 8-digit display.
//   CLK100MHZ  in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   value      in   4*NUM_DIGITS hex digits, digit i = value[4i+3:4i]
//   dp_in      in   per-digit decimal point request (1 = lit)
//   digit_en   in   per-digit enable (0 = dark)
//   lz_blank   in   1 = blank leading zeros (sampled when each slot latches)
//   load       in   capture strobe for value/dp_in/digit_en
//   AN         out  digit anodes, active-low, at most one low
//   CA..CG,DP  out  segments / decimal point, active-low
//   frame_done out  one-cycle pulse on the first GUARD cycle after the last digit
//   state_dbg  out  current scan FSM state
//
// Handshake: load is a plain strobe with no ready; every cycle with load=1
// overwrites the shadow registers, and no other cycle looks at those inputs.
//
// Each digit slot is REFRESH_DIV cycles: GUARD_CYCLES dark cycles, then the
// digit is shown. The segment code, DP and visibility are registered straight
// into the output flops on the GUARD->SHOW edge, so a load mid-slot cannot
// disturb the digit already on the display.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    CLK100MHZ,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic                    frame_done,
  output scan_state_t             state_dbg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;

  // Scan state
  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_done_q;

  // Per-digit visibility and the muxed current digit
  logic [NUM_DIGITS-1:0] nz_at_or_above;
  logic [NUM_DIGITS-1:0] visible;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_vis;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] an_sel;

  // nz_at_or_above[i] = some shadow digit j >= i is nonzero.
  always_comb begin
    logic any_nz;
    any_nz         = 1'b0;
    nz_at_or_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz            = any_nz | (|sh_value[4*i +: 4]);
      nz_at_or_above[i] = any_nz;
    end
  end

  // Digit 0 is never a leading zero, so it is forced into the mask.
  assign visible = sh_en & (lz_blank ? (nz_at_or_above | NUM_DIGITS'(1)) : '1);

  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_vis   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = sh_value[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_vis   = visible[i];
      end
    end
  end

  assign an_sel = ~(NUM_DIGITS'(1) << idx);

  hex_to_seg7 u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      state        <= GUARD;
      cnt          <= '0;
      idx          <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_en    <= digit_en;
      end

      frame_done_q <= 1'b0;

      case (state)
        GUARD: begin
          cnt <= cnt + 1'b1;
          if (cnt == GUARD_END) begin
            state <= SHOW;
            an_q  <= cur_vis ? an_sel : '1;
            seg_q <= cur_vis ? cur_seg : SEG_BLANK;
            dp_q  <= ~(cur_dp & cur_vis);
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state        <= GUARD;
            cnt          <= '0;
            idx          <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= (idx == IDX_LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= GUARD;
      endcase
    end
  end

  assign AN         = an_q;
  assign CA         = seg_q[6];
  assign CB         = seg_q[5];
  assign CC         = seg_q[4];
  assign CD         = seg_q[3];
  assign CE         = seg_q[2];
  assign CF         = seg_q[1];
  assign CG         = seg_q[0];
  assign DP         = dp_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with REFRESH_DIV=8, GUARD_CYCLES=2 (64-cycle frame).
// Outputs are sampled on the falling edge as one packed word
// {AN[7:0], CA..CG, DP, frame_done}.
module tb_seg7_scan_mux;
  import seg7_pkg::*;

  localparam int N  = 8;
  localparam int RD = 8;
  localparam int G  = 2;

  localparam logic [16:0] DARK    = {8'hFF, 7'h7F, 1'b1, 1'b0};
  localparam logic [16:0] DARK_FD = {8'hFF, 7'h7F, 1'b1, 1'b1};

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic        load;
  logic [7:0]  an;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic        frame_done;
  scan_state_t state_dbg;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (G)
  ) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .AN         (an),
    .CA         (ca),
    .CB         (cb),
    .CC         (cc),
    .CD         (cd),
    .CE         (ce),
    .CF         (cf),
    .CG         (cg),
    .DP         (dp),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];

  function automatic logic [16:0] obs();
    return {an, ca, cb, cc, cd, ce, cf, cg, dp, frame_done};
  endfunction

  task automatic check(input string name, input int tag, input logic [16:0] exp);
    logic [16:0] act;
    act = obs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got AN=%h seg=%b DP=%b fd=%b, want AN=%h seg=%b DP=%b fd=%b",
               name, tag, act[16:9], act[8:2], act[1], act[0],
               exp[16:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns one falling edge later with load low.
  task automatic load_inputs(input logic [31:0] v, input logic [7:0] d,
                             input logic [7:0] e, input logic lz);
    value    = v;
    dp_in    = d;
    digit_en = e;
    lz_blank = lz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Returns on the falling edge where frame_done is high (slot 0, cycle 0).
  task automatic wait_frame(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 4 * N * RD; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: frame_done not seen within %0d cycles, want a pulse", name, 4 * N * RD);
    end
  endtask

  typedef struct {
    logic [31:0]     value;
    logic [7:0]      dp;
    logic [7:0]      en;
    logic            lz;
    logic [7:0][7:0] an_exp;   // per slot, index = slot
    logic [7:0][6:0] seg_exp;  // per slot
    logic [7:0]      dp_exp;   // active-low DP per slot
  } vec_t;

  vec_t vecs[6];

  // Starts on the frame_done falling edge; checks all 64 cycles of one frame.
  task automatic check_frame(input string name, input vec_t v);
    logic [16:0] e;
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < RD; c++) begin
        if (c < G) exp_q.push_back((s == 0 && c == 0) ? DARK_FD : DARK);
        else       exp_q.push_back({v.an_exp[s], v.seg_exp[s], v.dp_exp[s], 1'b0});
      end
    end
    for (int n = 0; n < N * RD; n++) begin
      e = exp_q.pop_front();
      check(name, n, e);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 0..7 walk
    vecs[0].value   = 32'h7654_3210; vecs[0].dp = 8'h00; vecs[0].en = 8'hFF; vecs[0].lz = 1'b0;
    vecs[0].an_exp  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    vecs[0].seg_exp = {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01};
    vecs[0].dp_exp  = 8'hFF;
    // leading-zero blank: 0000_0A05
    vecs[1].value   = 32'h0000_0A05; vecs[1].dp = 8'h00; vecs[1].en = 8'hFF; vecs[1].lz = 1'b1;
    vecs[1].an_exp  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE};
    vecs[1].seg_exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h01, 7'h24};
    vecs[1].dp_exp  = 8'hFF;
    // leading-zero blank of all zeros: only digit 0
    vecs[2].value   = 32'h0000_0000; vecs[2].dp = 8'h00; vecs[2].en = 8'hFF; vecs[2].lz = 1'b1;
    vecs[2].an_exp  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    vecs[2].seg_exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01};
    vecs[2].dp_exp  = 8'hFF;
    // enable mask 0000_0101, DP on digit 2
    vecs[3].value   = 32'h7654_3210; vecs[3].dp = 8'h04; vecs[3].en = 8'h05; vecs[3].lz = 1'b0;
    vecs[3].an_exp  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFF, 8'hFE};
    vecs[3].seg_exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h01};
    vecs[3].dp_exp  = 8'hFB;
    // top digit nonzero keeps all zeros lit under lz_blank; DP on 0 and 7
    vecs[4].value   = 32'hF000_0000; vecs[4].dp = 8'h81; vecs[4].en = 8'hFF; vecs[4].lz = 1'b1;
    vecs[4].an_exp  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    vecs[4].seg_exp = {7'h38, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
    vecs[4].dp_exp  = 8'h7E;
    // remaining hex glyphs 8,9,b,C,d,E
    vecs[5].value   = 32'hEDCB_9800; vecs[5].dp = 8'h00; vecs[5].en = 8'hFF; vecs[5].lz = 1'b0;
    vecs[5].an_exp  = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    vecs[5].seg_exp = {7'h30, 7'h42, 7'h31, 7'h60, 7'h04, 7'h00, 7'h01, 7'h01};
    vecs[5].dp_exp  = 8'hFF;

    rst      = 1'b1;
    value    = '0;
    dp_in    = '0;
    digit_en = '0;
    lz_blank = 1'b0;
    load     = 1'b0;

    // Reset: dark throughout, then 2 dark cycles and 6 cycles of digit 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_hold", k, DARK);
    end
    rst = 1'b0;
    load_inputs(32'h0, 8'h00, 8'hFF, 1'b0);
    check("post_reset_guard", 1, DARK);
    for (int k = 2; k < RD; k++) begin
      @(negedge clk);
      check("post_reset_show", k, {8'hFE, 7'h01, 1'b1, 1'b0});
    end
    @(negedge clk);
    check("post_reset_slot1_guard", 8, DARK);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      load_inputs(vecs[i].value, vecs[i].dp, vecs[i].en, vecs[i].lz);
      wait_frame($sformatf("vec%0d_sync", i));
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-slot load: digit 1 keeps its code until its next slot.
    load_inputs(32'h7654_3210, 8'h00, 8'hFF, 1'b0);
    wait_frame("midload_sync");
    repeat (RD + 3) @(negedge clk);           // slot 1, cycle 3
    check("midload_before", 0, {8'hFD, 7'h4F, 1'b1, 1'b0});
    load_inputs(32'h7654_32F0, 8'h00, 8'hFF, 1'b0);
    for (int k = 4; k < RD; k++) begin
      check("midload_hold", k, {8'hFD, 7'h4F, 1'b1, 1'b0});
      @(negedge clk);
    end
    wait_frame("midload_sync2");
    repeat (RD + G) @(negedge clk);           // slot 1, cycle 2
    check("midload_new", 0, {8'hFD, 7'h38, 1'b1, 1'b0});

    // Reset during digit 5 SHOW.
    wait_frame("midreset_sync");
    repeat (5 * RD + 3) @(negedge clk);       // slot 5, cycle 3
    check("midreset_before", 0, {8'hDF, 7'h24, 1'b1, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    check("midreset_dark", 0, DARK);
    @(negedge clk);
    check("midreset_dark", 1, DARK);
    rst = 1'b0;
    // Shadow enables cleared: whole first frame dark, frame_done exactly 64 cycles on.
    for (int k = 1; k <= N * RD; k++) begin
      @(negedge clk);
      check("after_reset_frame", k, (k == N * RD) ? DARK_FD : DARK);
    end
    load_inputs(32'h0, 8'h00, 8'hFF, 1'b0);
    check("reload_guard", 1, DARK);
    @(negedge clk);
    check("reload_digit0", 2, {8'hFE, 7'h01, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
